riscv_if_id_queue: RTL and testbench
====================================

Name: riscv_if_id_queue

Overview:
- Parametrised, decoupled IF/ID pipeline stage: a DEPTH-entry circular fetch queue between fetch and decode.
- Replaces the single stall/flush register with a valid/ready handshake on both sides, and lets fetch run ahead of a stalled decoder.
- Carries PC, instruction word and a fetch-fault flag per entry.
- When empty or flushed, presents a canonical NOP bubble to decode.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction word width in bits.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0); ILEN bits wide.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all queued entries (branch mispredict or trap).
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  XLEN  PC of the fetched instruction.
- in_inst  input  ILEN  fetched instruction word.
- in_fault  input  1  instruction fetch access fault for this entry.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  XLEN  head PC; 0 when empty.
- out_inst  output  ILEN  head instruction; NOP_INST when empty.
- out_pc_plus4  output  XLEN  out_pc + 4, modulo 2^XLEN.
- out_fault  output  1  head fault flag; 0 when empty.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - storage array of DEPTH entries {pc, inst, fault};
  - head and tail pointers, log2(DEPTH) bits each, wrapping naturally;
  - count register, 0..DEPTH.
- Definitions: enq = in_valid & in_ready; deq = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready. A full queue therefore never accepts an entry, even in a cycle where it dequeues.
- out_valid = (count != 0). Head fields are read from storage[head] when out_valid=1. When out_valid=0, the outputs are forced to out_pc=0, out_inst=NOP_INST, out_fault=0, giving out_pc_plus4=4.
- Latency: an entry accepted at edge N is visible at the outputs after edge N. Empty-to-valid takes 1 cycle; there is no combinational bypass.
- Enqueue: write storage[tail], then tail <= tail+1.
- Dequeue: head <= head+1.
- count update:
  - +1 on enq only;
  - -1 on deq only;
  - unchanged on simultaneous enq & deq (legal whenever 0 < count < DEPTH).
- Flush is synchronous and has priority over enq and deq in the same cycle:
  - head, tail and count <= 0;
  - any concurrent in_valid entry is dropped;
  - out_valid=0 and NOP outputs from the next cycle;
  - storage contents are don't-care.
- Reset is identical to flush plus all storage pc/inst/fault set to 0/NOP_INST/0. Reset mid-operation discards everything.
- Output values after reset: in_ready=1, out_valid=0, out_pc=0, out_inst=NOP_INST, out_pc_plus4=4, out_fault=0, count=0.
- Pointer wrap-around: DEPTH is a power of two, so the pointers wrap by overflow. Entry order is preserved across the wrap.
- out_pc_plus4 is computed combinationally from out_pc; carry out of XLEN is discarded (32'hFFFF_FFFC -> 32'h0000_0000).
- A dequeue is impossible while empty and an enqueue is impossible while full: both are gated by the valid/ready terms, so count never under- or overflows.
- A fault entry is queued and delivered like any other entry. The block never interprets it.

Decomposition:
- Shared pipeline package holds:
  - constant NOP_INST default (32'h0000_0013);
  - XLEN/ILEN defaults;
  - the fetch-entry record typedef {pc, inst, fault}, reused by IF and ID.
- One sub-module is natural: riscv_fetch_queue_ram, a DEPTH x (XLEN+ILEN+1) register array with one write port and one asynchronous read port.
- Pointer, count and flush control stay in riscv_if_id_queue.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> count=0, out_valid=0, out_inst=0x00000013, out_pc=0, out_pc_plus4=4, in_ready=1.
- Fill and drain: out_ready=0, push pc 0x100,0x104,0x108,0x10C -> count=4 and in_ready=0; a 5th push is not accepted. Then out_ready=1 -> heads 0x100..0x10C in order, out_pc_plus4 0x104..0x110, then out_valid=0 with NOP.
- Streaming: in_valid=out_ready=1 continuously from empty -> first out_valid 1 cycle after first accept, count holds 1 thereafter, no entry lost across pointer wrap (push 10 sequential PCs, all 10 observed in order).
- Flush priority: count=3 with flush=1, in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0, the pushed entry never appears; the following push of pc 0x200 emerges as the next head.
- Fault and wrap: push pc 0xFFFFFFFC with in_fault=1 -> out_fault=1, out_pc_plus4=0x00000000; after dequeue out_fault=0 for a following clean entry.
- Reset mid-stream: count=2, assert rst with in_valid=1 -> identical to reset values; no stale entry is delivered afterwards.

Source files
------------

// File: rtl/riscv_if_id_queue_pkg.sv
// Shared IF/ID pipeline definitions: default widths, the canonical bubble
// instruction and the fetch-entry record passed from fetch to decode.
package riscv_if_id_queue_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ILEN_DEFAULT = 32;

    // addi x0, x0, 0 -- architecturally a no-op, used as the decode bubble.
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // One fetched instruction as seen by decode.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN_DEFAULT-1:0] inst;
        logic                    fault;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue_ram.sv
// Entry storage for the IF/ID fetch queue: DEPTH words, one synchronous
// write port and one asynchronous read port so the head entry is visible
// in the same cycle its pointer changes.
module riscv_fetch_queue_ram #(
    parameter int unsigned       DEPTH      = 4,
    parameter int unsigned       WIDTH      = 65,
    parameter logic [WIDTH-1:0]  RESET_WORD = '0,
    localparam int unsigned      AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Reset scrubs every word to the bubble pattern; otherwise write at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_WORD;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscv_if_id_queue.sv
// Decoupled IF/ID stage: a circular fetch queue with valid/ready on both
// sides. Fetch can run ahead of a stalled decoder by up to DEPTH entries;
// when the queue is empty decode sees a NOP bubble at PC 0.
module riscv_if_id_queue
    import riscv_if_id_queue_pkg::*;
#(
    parameter int unsigned      XLEN     = XLEN_DEFAULT,
    parameter int unsigned      ILEN     = ILEN_DEFAULT,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ILEN-1:0]  NOP_INST = ILEN'(NOP_INST_DEFAULT),
    localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_inst,
    input  logic            in_fault,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            out_fault,
    output logic [CW-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = XLEN + ILEN + 1;

    // Entry layout in storage: {pc, inst, fault}.
    localparam logic [EW-1:0] EMPTY_WORD = {{XLEN{1'b0}}, NOP_INST, 1'b0};

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq;
    logic          deq;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] rd_word;
    logic [XLEN-1:0] rd_pc;
    logic [ILEN-1:0] rd_inst;
    logic            rd_fault;

    // Handshake terms come only from registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign count     = count_q;

    assign wr_word = {in_pc, in_inst, in_fault};

    riscv_fetch_queue_ram #(
        .DEPTH      (DEPTH),
        .WIDTH      (EW),
        .RESET_WORD (EMPTY_WORD)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (enq & ~flush),
        .waddr_i (tail_q),
        .wdata_i (wr_word),
        .raddr_i (head_q),
        .rdata_o (rd_word)
    );

    assign rd_pc    = rd_word[EW-1 -: XLEN];
    assign rd_inst  = rd_word[ILEN:1];
    assign rd_fault = rd_word[0];

    // Head presentation: real entry when occupied, canonical bubble otherwise.
    always_comb begin
        out_pc    = '0;
        out_inst  = NOP_INST;
        out_fault = 1'b0;
        if (out_valid) begin
            out_pc    = rd_pc;
            out_inst  = rd_inst;
            out_fault = rd_fault;
        end
    end

    // Sequential PC; carry out of XLEN is intentionally dropped.
    assign out_pc_plus4 = out_pc + XLEN'(4);

    // Pointer/occupancy next state; flush wins over any same-cycle handshake.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + AW'(1);
            end
            if (deq) begin
                head_d = head_q + AW'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control registers; reset behaves like a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_riscv_if_id_queue.sv
// Self-checking bench for riscv_if_id_queue: a queue-level reference model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_riscv_if_id_queue;
    import riscv_if_id_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_fault = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_pc_plus4;
    logic        out_fault;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_entry_t mq[$];
    logic [31:0]  seen[$];
    bit           model_live = 1'b0;

    riscv_if_id_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_fault     (in_fault),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_pc_plus4 (out_pc_plus4),
        .out_fault    (out_fault),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic fault);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = pc ^ 32'hA5A5_0000;
        in_fault = fault;
        step();
        in_valid = 1'b0;
        in_fault = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_count"},     64'(count),        64'd0);
        cmp({tag, "_out_valid"}, 64'(out_valid),    64'd0);
        cmp({tag, "_out_inst"},  64'(out_inst),     64'h13);
        cmp({tag, "_out_pc"},    64'(out_pc),       64'd0);
        cmp({tag, "_plus4"},     64'(out_pc_plus4), 64'd4);
        cmp({tag, "_out_fault"}, 64'(out_fault),    64'd0);
        cmp({tag, "_in_ready"},  64'(in_ready),     64'd1);
    endtask

    // Reference model: an ordered list of accepted entries.
    initial begin
        bit m_enq, m_deq;
        fetch_entry_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                model_live = 1'b1;
            end else if (flush) begin
                mq.delete();
            end else begin
                m_enq = in_valid && (mq.size() != DEPTH);
                m_deq = (mq.size() != 0) && out_ready;
                if (m_deq) void'(mq.pop_front());
                if (m_enq) begin
                    e.pc = in_pc; e.inst = in_inst; e.fault = in_fault;
                    mq.push_back(e);
                    $display("ENQ pc=%h inst=%h fault=%0d", in_pc, in_inst, in_fault);
                end
            end
        end
    end

    // Compare process: every cycle, mid-period, against the model.
    initial begin
        logic [31:0] e_pc, e_inst;
        logic        e_fault;
        forever begin
            @(negedge clk);
            if (model_live) begin
                if (mq.size() != 0) begin
                    e_pc = mq[0].pc; e_inst = mq[0].inst; e_fault = mq[0].fault;
                end else begin
                    e_pc = '0; e_inst = NOP; e_fault = 1'b0;
                end
                cmp("m_out_valid", 64'(out_valid),    64'(mq.size() != 0));
                cmp("m_in_ready",  64'(in_ready),     64'(mq.size() != DEPTH));
                cmp("m_count",     64'(count),        64'(mq.size()));
                cmp("m_out_pc",    64'(out_pc),       64'(e_pc));
                cmp("m_out_inst",  64'(out_inst),     64'(e_inst));
                cmp("m_out_fault", 64'(out_fault),    64'(e_fault));
                cmp("m_plus4",     64'(out_pc_plus4), 64'(32'(e_pc + 32'd4)));
                if (out_valid && out_ready && !flush && !rst) begin
                    seen.push_back(out_pc);
                    $display("DEQ pc=%h inst=%h fault=%0d", out_pc, out_inst, out_fault);
                end
            end
        end
    end

    initial begin
        // Reset with fetch pushing.
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD_0000; in_inst = 32'h1;
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        check_reset_values("reset");

        // Fill and drain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 1'b0);
        cmp("fill_count", 64'(count), 64'd4);
        cmp("fill_in_ready", 64'(in_ready), 64'd0);
        push(32'h110, 1'b0);
        cmp("fill_5th_count", 64'(count), 64'd4);
        seen.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmp("drain_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
            cmp("drain_plus4", 64'(out_pc_plus4), 64'(32'h104 + 32'(4 * i)));
            step();
        end
        cmp("drain_valid", 64'(out_valid), 64'd0);
        cmp("drain_nop", 64'(out_inst), 64'h13);
        cmp("drain_seen", 64'(seen.size()), 64'd4);

        // Streaming across pointer wrap.
        seen.delete();
        cmp("stream_pre_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 10; i++) begin
            push(32'h1000 + 32'(4 * i), 1'b0);
            in_valid = 1'b0;
            cmp("stream_valid", 64'(out_valid), 64'd1);
            cmp("stream_count", 64'(count), 64'd1);
        end
        step();
        cmp("stream_seen_n", 64'(seen.size()), 64'd10);
        for (int i = 0; i < seen.size() && i < 10; i++)
            cmp("stream_order", 64'(seen[i]), 64'(32'h1000 + 32'(4 * i)));

        // Flush has priority over a same-cycle push and pop.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i), 1'b0);
        cmp("flush_pre_count", 64'(count), 64'd3);
        seen.delete();
        flush = 1'b1; out_ready = 1'b1;
        push(32'h30C, 1'b0);
        flush = 1'b0; out_ready = 1'b0;
        cmp("flush_count", 64'(count), 64'd0);
        cmp("flush_valid", 64'(out_valid), 64'd0);
        cmp("flush_nop", 64'(out_inst), 64'h13);
        push(32'h200, 1'b0);
        cmp("flush_next_pc", 64'(out_pc), 64'h200);
        cmp("flush_next_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        cmp("flush_seen_n", 64'(seen.size()), 64'd1);
        if (seen.size() > 0) cmp("flush_seen_pc", 64'(seen[0]), 64'h200);

        // Fault entry with PC wrap.
        push(32'hFFFF_FFFC, 1'b1);
        cmp("fault_flag", 64'(out_fault), 64'd1);
        cmp("fault_plus4", 64'(out_pc_plus4), 64'h0);
        push(32'h400, 1'b0);
        out_ready = 1'b1;
        step();
        cmp("fault_next_pc", 64'(out_pc), 64'h400);
        cmp("fault_next_flag", 64'(out_fault), 64'd0);
        cmp("fault_next_plus4", 64'(out_pc_plus4), 64'h404);
        step();
        out_ready = 1'b0;

        // Reset in the middle of traffic.
        push(32'h500, 1'b0);
        push(32'h504, 1'b0);
        cmp("mid_pre_count", 64'(count), 64'd2);
        seen.delete();
        rst = 1'b1;
        push(32'h508, 1'b0);
        rst = 1'b0;
        check_reset_values("midrst");
        out_ready = 1'b1;
        step(); step(); step();
        cmp("midrst_no_stale", 64'(seen.size()), 64'd0);
        cmp("midrst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
